// File: rtl/psk_rx_ctrl.sv
// PSK31 receive controller: preamble lock / squelch sequencing in front of a
// show-ahead character FIFO that feeds the software consumer.
module psk_rx_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int PREAMBLE_ZEROS = 16,
  parameter int TIMEOUT_SYMS   = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_en,
  input  logic                          sym_tick,
  input  logic                          bit_in,
  input  logic [7:0]                    char_in,
  input  logic                          char_in_valid,
  input  logic                          rd_en,
  input  logic                          ovf_clr,
  output logic                          dec_enable,
  output logic [1:0]                    state,
  output logic [7:0]                    rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  // state    | meaning
  // IDLE     | receiver disabled, clock recovery held off
  // ACQUIRE  | counting consecutive zero bits of the preamble
  // LOCKED   | accepting characters, watching for carrier loss
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10
  } state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int ZW = $clog2(PREAMBLE_ZEROS + 1);
  localparam int TW = $clog2(TIMEOUT_SYMS + 1);
  localparam logic [ZW-1:0] ZERO_LOCK = ZW'(PREAMBLE_ZEROS);
  localparam logic [TW-1:0] SYM_LIMIT = TW'(TIMEOUT_SYMS);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  state_t          state_q, state_d;
  logic            dec_enable_q, dec_enable_d;
  logic [ZW-1:0]   zero_cnt_q, zero_cnt_d;
  logic [TW-1:0]   sym_timer_q, sym_timer_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];

  logic            wr_req, rd_ok, wr_ok, drop;

  always_comb begin
    state_d     = state_q;
    zero_cnt_d  = zero_cnt_q;
    sym_timer_d = sym_timer_q;
    if (!rx_en) begin
      state_d     = ST_IDLE;
      zero_cnt_d  = '0;
      sym_timer_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_ACQUIRE;
          zero_cnt_d  = '0;
          sym_timer_d = '0;
        end
        ST_ACQUIRE: begin
          if (zero_cnt_q == ZERO_LOCK) begin
            state_d     = ST_LOCKED;
            sym_timer_d = '0;
          end else if (sym_tick) begin
            zero_cnt_d = bit_in ? '0 : zero_cnt_q + ZW'(1);
          end
        end
        ST_LOCKED: begin
          if (sym_timer_q == SYM_LIMIT) begin
            state_d     = ST_ACQUIRE;
            sym_timer_d = '0;
            zero_cnt_d  = '0;
          end else if (char_in_valid) begin
            sym_timer_d = '0;
          end else if (sym_tick) begin
            sym_timer_d = sym_timer_q + TW'(1);
          end
        end
        default: begin
          state_d     = ST_IDLE;
          zero_cnt_d  = '0;
          sym_timer_d = '0;
        end
      endcase
    end
    dec_enable_d = (state_d != ST_IDLE);
  end

  // A write into a full FIFO is legal when the head is popped in the same cycle.
  always_comb begin
    wr_req     = char_in_valid && (state_q == ST_LOCKED);
    rd_ok      = rd_en && (count_q != '0);
    wr_ok      = wr_req && ((count_q != DEPTH) || rd_ok);
    drop       = wr_req && (count_q == DEPTH) && !rd_ok;
    wr_ptr_d   = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_ok && !rd_ok) count_d = count_q + CW'(1);
    if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dec_enable_q <= 1'b0;
      zero_cnt_q   <= '0;
      sym_timer_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_enable_q <= dec_enable_d;
      zero_cnt_q   <= zero_cnt_d;
      sym_timer_q  <= sym_timer_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) fifo_mem[wr_ptr_q] <= char_in;
  end

  // Storage is not reset, so the head is gated to zero whenever the FIFO is empty.
  assign rd_data    = (count_q == '0) ? 8'h00 : fifo_mem[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign dec_enable = dec_enable_q;
  assign state      = state_q;

endmodule
